conv_gpio_sequencer: RTL and testbench
======================================

# conv_gpio_sequencer

Command sequencer between the MicroBlaze GPIO pair and the 2D convolution datapath. Decodes 32-bit command words written on the GPIO output and drives kernel-coefficient writes, image-RAM writes, convolution start and result reads into the datapath. Returns status, handshake and read data on the GPIO input. Sits inside the simulation/processing wrapper, clocked by the MicroBlaze-generated system clock.

## Interface
- BIT_LEN, 8, pixel/coefficient width
- M_LEN, 3, kernel side; kernel has M_LEN*M_LEN coefficients
- NB_ADDRESS, 10, image/result RAM address width
- RAM_WIDTH, 13, result word width
- GPIO_D, 32, GPIO word width
---
- CLK100MHZ  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- gpio_o_data_tri_o  in  GPIO_D  command word from MicroBlaze
- gpio_i_data_tri_i  out  GPIO_D  status/read word to MicroBlaze
- o_kernel_we  out  1  coefficient write strobe
- o_kernel_idx  out  4  coefficient index 0..M_LEN*M_LEN-1
- o_kernel_data  out  BIT_LEN  coefficient value
- o_ram_we  out  1  image RAM write strobe
- o_ram_re  out  1  result RAM read strobe
- o_ram_addr  out  NB_ADDRESS  RAM address
- o_ram_data  out  BIT_LEN  image pixel
- i_ram_rdata  in  RAM_WIDTH  result RAM read data, valid 1 cycle after o_ram_re
- o_conv_start  out  1  one-cycle start pulse
- i_conv_done  in  1  one-cycle done pulse from datapath

## Operation
- Command word: [31:29] opcode, [28] toggle, [27:18] address, [7:0] data.
- New command = toggle bit differs from registered previous toggle; level of other bits irrelevant otherwise. Repeated identical words never re-execute.
- Opcodes: 0 NOP, 1 WR_KERNEL (idx = addr[3:0]), 2 WR_IMG, 3 START, 4 RD_RESULT, 5 CLR_DONE, 6-7 illegal.
- Status word: [31] busy, [30] done (sticky), [29] ack toggle, [28] err, [27:RAM_WIDTH] zero, [RAM_WIDTH-1:0] last read data.
- Ack toggle copies command toggle once the command completes (or is dropped); MicroBlaze polls bit 29 == sent toggle.
- FSM states: IDLE, EXEC, READ_WAIT, RUN.
  - IDLE: on new command -> EXEC, latch opcode/addr/data.
  - EXEC: WR_KERNEL/WR_IMG assert strobe 1 cycle, ack, -> IDLE. START: pulse o_conv_start, clear done, set busy, ack, -> RUN. RD_RESULT: pulse o_ram_re -> READ_WAIT. CLR_DONE: clear done, ack, -> IDLE. NOP/illegal/idx>=M_LEN*M_LEN: no strobe, ack, -> IDLE.
  - READ_WAIT: capture i_ram_rdata, ack, -> IDLE.
  - RUN: commands still decoded; WR_KERNEL, WR_IMG, START dropped (acked, no strobe); RD_RESULT and CLR_DONE allowed. On i_conv_done: busy=0, done=1, -> IDLE.
- i_conv_done outside RUN ignored.
- o_ram_addr/o_kernel_data/o_ram_data hold latched values between commands.

## Timing
- Reset: all outputs 0, status word 0, previous-toggle reg 0, FSM IDLE. Reset mid-RUN abandons run; datapath reset is its own concern.
- New toggle visible cycle N -> EXEC at N+1 (strobe/start/re high during N+1).
- Writes, START, CLR_DONE, NOP: ack toggle updated at N+2.
- RD_RESULT: o_ram_re at N+1, data captured and ack at N+2 (visible N+3 status word).
- i_conv_done same cycle as a new command in RUN: done processed, command handled from IDLE next cycle (not lost; toggle compare still pending).
- Min command spacing 3 cycles; firmware guarantees it via ack polling.

## Configuration
- CONV_SEQ_ERR_EN defined: status[28] sticky err, set by illegal opcode, bad kernel index, or command dropped in RUN; cleared by CLR_DONE or reset.
- Undefined: status[28] tied 0, same drop behaviour, no err register.

## Structure
- Shared package: opcode constants, status/command bit positions, FSM state encoding.
- Sub-module conv_seq_cmd_decode: toggle edge detect plus field extraction and opcode/index legality check.

## Test plan
- Reset asserted mid-RUN -> status 0, o_conv_start 0, FSM IDLE next edge.
- WR_KERNEL idx 4 data 0x7F, toggle 1 -> o_kernel_we high at N+1 with idx 4, data 0x7F; status[29]=1 at N+2.
- Same word held 20 cycles -> exactly one o_kernel_we pulse.
- START -> o_conv_start 1 cycle, status[31]=1; WR_IMG during RUN -> no o_ram_we, acked, err=1 (macro on); i_conv_done -> status[31]=0, [30]=1.
- RD_RESULT addr 0x3FF, i_ram_rdata 0x1ABC -> o_ram_re at N+1, status[12:0]=0x1ABC with ack at N+2.
- Opcode 7 -> no strobes, ack, err=1 with CONV_SEQ_ERR_EN, err=0 without.

Source files
------------

// File: rtl/conv_gpio_sequencer_pkg.sv
// Shared definitions for the GPIO command sequencer: opcodes, command/status bit
// positions and FSM state encoding.
package conv_gpio_sequencer_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WR_KERNEL = 3'd1;
  localparam logic [2:0] OP_WR_IMG    = 3'd2;
  localparam logic [2:0] OP_START     = 3'd3;
  localparam logic [2:0] OP_RD_RESULT = 3'd4;
  localparam logic [2:0] OP_CLR_DONE  = 3'd5;

  localparam int CMD_OP_LO   = 29;
  localparam int CMD_TOGGLE  = 28;
  localparam int CMD_ADDR_LO = 18;

  localparam int STAT_BUSY = 31;
  localparam int STAT_DONE = 30;
  localparam int STAT_ACK  = 29;
  localparam int STAT_ERR  = 28;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_CLR_DONE);
  endfunction

endpackage

// File: rtl/conv_gpio_sequencer_cmd_decode.sv
// Command word decoder: toggle edge detect against the last consumed toggle,
// field extraction and opcode/kernel-index legality.
module conv_seq_cmd_decode
  import conv_gpio_sequencer_pkg::*;
#(
  parameter int GPIO_D     = 32,
  parameter int NB_ADDRESS = 10,
  parameter int BIT_LEN    = 8,
  parameter int M_LEN      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_D-1:0]     cmd_word,
  input  logic                  consume,
  output logic                  new_cmd,
  output logic [2:0]            opcode,
  output logic                  toggle,
  output logic [NB_ADDRESS-1:0] addr,
  output logic [BIT_LEN-1:0]    data,
  output logic                  cmd_ok
);

  logic prev_toggle_r;
  logic idx_ok_s;

  // Previous toggle only advances when the sequencer actually takes the command,
  // so a command arriving while a run is finishing stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_toggle_r <= 1'b0;
    end else if (consume) begin
      prev_toggle_r <= cmd_word[CMD_TOGGLE];
    end
  end

  assign toggle   = cmd_word[CMD_TOGGLE];
  assign new_cmd  = (cmd_word[CMD_TOGGLE] != prev_toggle_r);
  assign opcode   = cmd_word[CMD_OP_LO +: 3];
  assign addr     = cmd_word[CMD_ADDR_LO +: NB_ADDRESS];
  assign data     = cmd_word[BIT_LEN-1:0];
  assign idx_ok_s = ({28'd0, cmd_word[CMD_ADDR_LO +: 4]} < 32'(M_LEN * M_LEN));
  assign cmd_ok   = op_is_legal(opcode) && ((opcode != OP_WR_KERNEL) || idx_ok_s);

endmodule

// File: rtl/conv_gpio_sequencer.sv
// GPIO command sequencer for the 2D convolution datapath.
// Optional sticky error flag in status[28] enabled by defining CONV_SEQ_ERR_EN.
module conv_gpio_sequencer
  import conv_gpio_sequencer_pkg::*;
#(
  parameter int BIT_LEN    = 8,
  parameter int M_LEN      = 3,
  parameter int NB_ADDRESS = 10,
  parameter int RAM_WIDTH  = 13,
  parameter int GPIO_D     = 32
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic [GPIO_D-1:0]     gpio_o_data_tri_o,
  output logic [GPIO_D-1:0]     gpio_i_data_tri_i,
  output logic                  o_kernel_we,
  output logic [3:0]            o_kernel_idx,
  output logic [BIT_LEN-1:0]    o_kernel_data,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [NB_ADDRESS-1:0] o_ram_addr,
  output logic [BIT_LEN-1:0]    o_ram_data,
  input  logic [RAM_WIDTH-1:0]  i_ram_rdata,
  output logic                  o_conv_start,
  input  logic                  i_conv_done
);

  state_t state_r, state_d, ret_s;

  logic                  new_cmd_s, toggle_s, cmd_ok_s, consume_s, err_s;
  logic [2:0]            opcode_s;
  logic [NB_ADDRESS-1:0] addr_s;
  logic [BIT_LEN-1:0]    data_s;

  logic [2:0]            op_r;
  logic                  toggle_r;
  logic [NB_ADDRESS-1:0] addr_r;
  logic [BIT_LEN-1:0]    data_r;
  logic                  kernel_we_r, ram_we_r, ram_re_r, start_r;
  logic                  kernel_we_d, ram_we_d, ram_re_d, start_d;
  logic                  busy_r, done_r, ack_r;
  logic                  busy_d, done_d, ack_d;
  logic [RAM_WIDTH-1:0]  rdata_r, rdata_d;
  logic                  run_end_s;

  conv_seq_cmd_decode #(
    .GPIO_D    (GPIO_D),
    .NB_ADDRESS(NB_ADDRESS),
    .BIT_LEN   (BIT_LEN),
    .M_LEN     (M_LEN)
  ) u_decode (
    .clk     (CLK100MHZ),
    .rst     (reset),
    .cmd_word(gpio_o_data_tri_o),
    .consume (consume_s),
    .new_cmd (new_cmd_s),
    .opcode  (opcode_s),
    .toggle  (toggle_s),
    .addr    (addr_s),
    .data    (data_s),
    .cmd_ok  (cmd_ok_s)
  );

  // A done pulse only counts while a run is in flight.
  assign run_end_s = busy_r && i_conv_done;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  always_comb begin
    state_d     = state_r;
    ret_s       = (busy_r && !i_conv_done) ? ST_RUN : ST_IDLE;
    consume_s   = 1'b0;
    kernel_we_d = 1'b0;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    start_d     = 1'b0;
    busy_d      = busy_r;
    done_d      = done_r;
    ack_d       = ack_r;
    rdata_d     = rdata_r;
    if (run_end_s) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else begin
      busy_d = busy_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (new_cmd_s) begin
          consume_s   = 1'b1;
          state_d     = ST_EXEC;
          kernel_we_d = (opcode_s == OP_WR_KERNEL) && cmd_ok_s;
          ram_we_d    = (opcode_s == OP_WR_IMG);
          start_d     = (opcode_s == OP_START);
          ram_re_d    = (opcode_s == OP_RD_RESULT);
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Writes and START are dropped while running; reads still go through.
      ST_RUN: begin
        if (i_conv_done) begin
          state_d = ST_IDLE;
        end else if (new_cmd_s) begin
          consume_s = 1'b1;
          state_d   = ST_EXEC;
          ram_re_d  = (opcode_s == OP_RD_RESULT);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_EXEC: begin
        ack_d = toggle_r;
        case (op_r)
          OP_START: begin
            if (!busy_r) begin
              busy_d = 1'b1;
              done_d = 1'b0;
              ret_s  = ST_RUN;
            end else begin
              ret_s = ret_s;
            end
          end
          OP_RD_RESULT: ack_d  = ack_r;
          OP_CLR_DONE:  done_d = run_end_s;
          default:      ack_d  = toggle_r;
        endcase
        state_d = (op_r == OP_RD_RESULT) ? ST_READ_WAIT : ret_s;
      end
      ST_READ_WAIT: begin
        rdata_d = i_ram_rdata;
        ack_d   = toggle_r;
        state_d = ret_s;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      op_r        <= 3'd0;
      toggle_r    <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      kernel_we_r <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_re_r    <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ack_r       <= 1'b0;
      rdata_r     <= '0;
    end else begin
      kernel_we_r <= kernel_we_d;
      ram_we_r    <= ram_we_d;
      ram_re_r    <= ram_re_d;
      start_r     <= start_d;
      busy_r      <= busy_d;
      done_r      <= done_d;
      ack_r       <= ack_d;
      rdata_r     <= rdata_d;
      if (consume_s) begin
        op_r     <= opcode_s;
        toggle_r <= toggle_s;
        addr_r   <= addr_s;
        data_r   <= data_s;
      end
    end
  end

`ifdef CONV_SEQ_ERR_EN
  logic fault_r, err_r, err_d;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      fault_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= err_d;
      if (consume_s) begin
        fault_r <= ~cmd_ok_s;
      end
    end
  end

  // Sticky until CLR_DONE: illegal opcode, bad kernel index, or a dropped command.
  always_comb begin
    err_d = err_r;
    if (state_r == ST_EXEC) begin
      if (op_r == OP_CLR_DONE) begin
        err_d = 1'b0;
      end else if (fault_r) begin
        err_d = 1'b1;
      end else if (busy_r && ((op_r == OP_WR_KERNEL) || (op_r == OP_WR_IMG) ||
                              (op_r == OP_START))) begin
        err_d = 1'b1;
      end else begin
        err_d = err_r;
      end
    end else begin
      err_d = err_r;
    end
  end

  assign err_s = err_r;
`else
  assign err_s = 1'b0;
`endif

  assign o_kernel_we   = kernel_we_r;
  assign o_kernel_idx  = addr_r[3:0];
  assign o_kernel_data = data_r;
  assign o_ram_we      = ram_we_r;
  assign o_ram_re      = ram_re_r;
  assign o_ram_addr    = addr_r;
  assign o_ram_data    = data_r;
  assign o_conv_start  = start_r;

  assign gpio_i_data_tri_i = {busy_r, done_r, ack_r, err_s,
                              {(GPIO_D-4-RAM_WIDTH){1'b0}}, rdata_r};

endmodule

// File: tb/tb_conv_gpio_sequencer.sv
// Directed, table-driven bench for conv_gpio_sequencer; err expectations follow CONV_SEQ_ERR_EN.
module tb_conv_gpio_sequencer;

`ifdef CONV_SEQ_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_o;
  logic [31:0] gpio_i;
  logic        kernel_we, ram_we, ram_re, conv_start, conv_done;
  logic [3:0]  kernel_idx;
  logic [7:0]  kernel_data, ram_data;
  logic [9:0]  ram_addr;
  logic [12:0] ram_rdata;

  int   tests = 0;
  int   fails = 0;
  logic tog   = 1'b0;

  always #5 clk = ~clk;

  conv_gpio_sequencer dut (
    .CLK100MHZ        (clk),
    .reset            (reset),
    .gpio_o_data_tri_o(gpio_o),
    .gpio_i_data_tri_i(gpio_i),
    .o_kernel_we      (kernel_we),
    .o_kernel_idx     (kernel_idx),
    .o_kernel_data    (kernel_data),
    .o_ram_we         (ram_we),
    .o_ram_re         (ram_re),
    .o_ram_addr       (ram_addr),
    .o_ram_data       (ram_data),
    .i_ram_rdata      (ram_rdata),
    .o_conv_start     (conv_start),
    .i_conv_done      (conv_done)
  );

  typedef struct {
    logic [2:0]  op;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic [12:0] rdata;
    logic [3:0]  strb;      // {kernel_we, ram_we, ram_re, conv_start} at N+1
    bit          ack_late;  // ack only at N+3 (reads)
    bit          err;       // expected err with the feature enabled
    logic [12:0] rd;        // expected status read data at N+3
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [9:0] addr, input logic [7:0] data);
    tog    = ~tog;
    gpio_o = {op, tog, addr, 10'd0, data};
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, kernel_we, ram_we, ram_re, conv_start};
  endfunction

  initial begin
    int cnt;
    vecs[0]  = '{3'd1, 10'h004, 8'h7F, 13'h0000, 4'b1000, 1'b0, 1'b0, 13'h0000};
    vecs[1]  = '{3'd2, 10'h155, 8'hA5, 13'h0000, 4'b0100, 1'b0, 1'b0, 13'h0000};
    vecs[2]  = '{3'd4, 10'h3FF, 8'h00, 13'h1ABC, 4'b0010, 1'b1, 1'b0, 13'h1ABC};
    vecs[3]  = '{3'd1, 10'h009, 8'h11, 13'h0000, 4'b0000, 1'b0, 1'b1, 13'h1ABC};
    vecs[4]  = '{3'd5, 10'h000, 8'h00, 13'h0000, 4'b0000, 1'b0, 1'b0, 13'h1ABC};
    vecs[5]  = '{3'd7, 10'h001, 8'h22, 13'h0000, 4'b0000, 1'b0, 1'b1, 13'h1ABC};
    vecs[6]  = '{3'd0, 10'h002, 8'h33, 13'h0000, 4'b0000, 1'b0, 1'b1, 13'h1ABC};
    vecs[7]  = '{3'd1, 10'h008, 8'h80, 13'h0000, 4'b1000, 1'b0, 1'b1, 13'h1ABC};
    vecs[8]  = '{3'd6, 10'h003, 8'h44, 13'h0000, 4'b0000, 1'b0, 1'b1, 13'h1ABC};
    vecs[9]  = '{3'd5, 10'h000, 8'h00, 13'h0000, 4'b0000, 1'b0, 1'b0, 13'h1ABC};
    vecs[10] = '{3'd4, 10'h000, 8'h00, 13'h0001, 4'b0010, 1'b1, 1'b0, 13'h0001};

    reset = 1'b1; gpio_o = 32'd0; conv_done = 1'b0; ram_rdata = 13'd0;
    repeat (3) tick;
    chk("reset status", gpio_i, 32'd0);
    chk("reset strobes", strobes(), 32'd0);
    chk("reset addr", {22'd0, ram_addr}, 32'd0);
    reset = 1'b0;
    tick;
    chk("post-reset status", gpio_i, 32'd0);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      ram_rdata = 13'd0;
      tick;  // N+1
      chk($sformatf("v%0d strobes", i), strobes(), {28'd0, vecs[i].strb});
      chk($sformatf("v%0d addr", i), {22'd0, ram_addr}, {22'd0, vecs[i].addr});
      chk($sformatf("v%0d kidx", i), {28'd0, kernel_idx}, {28'd0, vecs[i].addr[3:0]});
      chk($sformatf("v%0d kdata", i), {24'd0, kernel_data}, {24'd0, vecs[i].data});
      chk($sformatf("v%0d rdata_out", i), {24'd0, ram_data}, {24'd0, vecs[i].data});
      ram_rdata = vecs[i].rdata;
      tick;  // N+2
      chk($sformatf("v%0d strobes N+2", i), strobes(), 32'd0);
      chk($sformatf("v%0d ack N+2", i), {31'd0, gpio_i[29]},
          {31'd0, (vecs[i].ack_late ? ~tog : tog)});
      tick;  // N+3
      chk($sformatf("v%0d status", i), gpio_i,
          {1'b0, 1'b0, tog, vecs[i].err & ERR_ON, 15'd0, vecs[i].rd});
    end

    // Held word must execute exactly once.
    send(3'd1, 10'h001, 8'h33);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      cnt += int'(kernel_we);
    end
    chk("held word pulses", cnt, 32'd1);

    // START, dropped write, read during run, then done.
    send(3'd3, 10'h000, 8'h00);
    tick;
    chk("start pulse", {31'd0, conv_start}, 32'd1);
    tick;
    chk("start single cycle", {31'd0, conv_start}, 32'd0);
    chk("run busy/ack", {29'd0, gpio_i[31:29]}, {29'd0, 1'b1, 1'b0, tog});
    tick;
    send(3'd2, 10'h0AA, 8'h5A);
    tick;
    chk("run wr_img N+1", strobes(), 32'd0);
    tick;
    chk("run wr_img N+2", strobes(), 32'd0);
    chk("run wr_img ack", {31'd0, gpio_i[29]}, {31'd0, tog});
    tick;
    chk("run wr_img err", {28'd0, gpio_i[31:28]}, {28'd0, 1'b1, 1'b0, tog, ERR_ON});
    send(3'd4, 10'h010, 8'h00);
    ram_rdata = 13'd0;
    tick;
    chk("run rd re", strobes(), 32'd2);
    ram_rdata = 13'h0F0F;
    tick;
    tick;
    chk("run rd status", gpio_i, {1'b1, 1'b0, tog, ERR_ON, 15'd0, 13'h0F0F});
    conv_done = 1'b1;
    tick;
    conv_done = 1'b0;
    chk("done sets", {30'd0, gpio_i[31:30]}, 32'd1);
    tick;
    chk("done sticky", {30'd0, gpio_i[31:30]}, 32'd1);

    // CLR_DONE, then a done pulse while idle is ignored.
    send(3'd5, 10'h000, 8'h00);
    repeat (3) tick;
    chk("clr_done", {28'd0, gpio_i[31:28]}, {28'd0, 1'b0, 1'b0, tog, 1'b0});
    conv_done = 1'b1;
    tick;
    conv_done = 1'b0;
    tick;
    chk("idle done ignored", {31'd0, gpio_i[30]}, 32'd0);

    // Done arriving with a new command: command runs one cycle later, not lost.
    send(3'd3, 10'h000, 8'h00);
    tick;
    tick;
    chk("run2 busy", {30'd0, gpio_i[31:30]}, 32'd2);
    tick;
    send(3'd1, 10'h002, 8'h42);
    conv_done = 1'b1;
    tick;
    conv_done = 1'b0;
    chk("coincide no we yet", {31'd0, kernel_we}, 32'd0);
    chk("coincide done", {30'd0, gpio_i[31:30]}, 32'd1);
    tick;
    chk("coincide we", {31'd0, kernel_we}, 32'd1);
    chk("coincide idx", {28'd0, kernel_idx}, 32'd2);
    tick;
    chk("coincide ack/err", {30'd0, gpio_i[29:28]}, {30'd0, tog, 1'b0});

    // Reset in the middle of a run.
    send(3'd3, 10'h000, 8'h00);
    tick;
    tick;
    reset = 1'b1; gpio_o = 32'd0; tog = 1'b0;
    #1;
    chk("midrun reset status", gpio_i, 32'd0);
    chk("midrun reset strobes", strobes(), 32'd0);
    tick;
    reset = 1'b0;
    tick;
    send(3'd1, 10'h003, 8'h12);
    tick;
    chk("after reset we", {31'd0, kernel_we}, 32'd1);
    tick;
    chk("after reset status", gpio_i, 32'h2000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
